// File: rtl/user_pkg.sv
// User-domain shared definitions: address map, arbiter sizing and the manager-index type.
package user_pkg;

   localparam logic [31:0] UserRomBase   = 32'h2000_0000;
   localparam logic [31:0] UserRomMask   = 32'h0000_0FFF;
   localparam logic [31:0] UserRegsBase  = 32'h2000_1000;
   localparam logic [31:0] UserRegsMask  = 32'h0000_0FFF;
   localparam logic [31:0] UserSramBase  = 32'h2001_0000;
   localparam logic [31:0] UserSramMask  = 32'h0000_FFFF;

   localparam int unsigned UserArbNumMgr   = 2;
   localparam int unsigned UserArbMaxTrans = 2;
   localparam int unsigned UserArbMaxMgr   = 8;
   localparam int unsigned UserArbIdxW     = (UserArbNumMgr > 1) ? $clog2(UserArbNumMgr) : 1;

   typedef logic [UserArbIdxW-1:0] user_mgr_idx_t;

   typedef enum logic [0:0] {
      ArbIdle = 1'b0,
      ArbHold = 1'b1
   } user_arb_state_e;

   // First requester at or after ptr, scanning upward with wrap; returns ptr when nobody requests.
   function automatic int unsigned user_arb_rr_pick(input logic [UserArbMaxMgr-1:0] req,
                                                    input int unsigned               ptr,
                                                    input int unsigned               num);
      int unsigned pick;
      int unsigned cand;
      logic        found;
      pick  = ptr;
      found = 1'b0;
      for (int unsigned k = 0; k < UserArbMaxMgr; k++) begin
         cand = (ptr + k) % num;
         if (k < num && !found && req[cand[2:0]]) begin
            pick  = cand;
            found = 1'b1;
         end
      end
      return pick;
   endfunction

endpackage

// File: rtl/user_arb_id_fifo.sv
// In-order FIFO of granted manager indices; the head names the owner of the next response.
module user_arb_id_fifo #(
   parameter int unsigned Depth = 2,
   parameter int unsigned Width = 1,
   localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1,
   localparam int unsigned CntW = $clog2(Depth + 1)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             push_i,
   input  logic [Width-1:0] push_data_i,
   input  logic             pop_i,
   output logic [Width-1:0] head_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [CntW-1:0]  count_o
);

   logic [Width-1:0] mem_q [Depth];
   logic [PtrW-1:0]  wptr_q, wptr_d;
   logic [PtrW-1:0]  rptr_q, rptr_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic             do_push, do_pop;

   assign full_o  = (cnt_q == CntW'(Depth));
   assign empty_o = (cnt_q == '0);
   assign count_o = cnt_q;
   assign head_o  = mem_q[rptr_q];
   assign do_push = push_i & ~full_o;
   assign do_pop  = pop_i & ~empty_o;

   always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      cnt_d  = cnt_q;
      if (do_push) wptr_d = (wptr_q == PtrW'(Depth - 1)) ? '0 : wptr_q + 1'b1;
      if (do_pop)  rptr_d = (rptr_q == PtrW'(Depth - 1)) ? '0 : rptr_q + 1'b1;
      case ({do_push, do_pop})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
         for (int i = 0; i < int'(Depth); i++) mem_q[i] <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         cnt_q  <= cnt_d;
         if (do_push) mem_q[wptr_q] <= push_data_i;
      end
   end

endmodule

// File: rtl/user_obi_arbiter.sv
// Round-robin OBI arbiter folding NumMgr managers onto one user-domain subordinate port,
// with in-order response routing limited to MaxTrans outstanding transactions.
//
// state   | meaning
// --------+------------------------------------------------------------
// ArbIdle | no request waiting on the subordinate; selection is free
// ArbHold | request issued without grant; selection frozen until gnt
module user_obi_arbiter
   import user_pkg::*;
#(
   parameter int unsigned NumMgr   = UserArbNumMgr,
   parameter int unsigned MaxTrans = UserArbMaxTrans
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic [NumMgr-1:0]      mgr_req_i,
   output logic [NumMgr-1:0]      mgr_gnt_o,
   input  logic [NumMgr*32-1:0]   mgr_addr_i,
   input  logic [NumMgr*32-1:0]   mgr_wdata_i,
   input  logic [NumMgr-1:0]      mgr_we_i,
   input  logic [NumMgr*4-1:0]    mgr_be_i,
   output logic [NumMgr-1:0]      mgr_rvalid_o,
   output logic [NumMgr-1:0]      mgr_err_o,
   output logic [NumMgr*32-1:0]   mgr_rdata_o,
   output logic                   sbr_req_o,
   output logic [31:0]            sbr_addr_o,
   output logic                   sbr_we_o,
   output logic [3:0]             sbr_be_o,
   output logic [31:0]            sbr_wdata_o,
   input  logic                   sbr_gnt_i,
   input  logic                   sbr_rvalid_i,
   input  logic                   sbr_err_i,
   input  logic [31:0]            sbr_rdata_i,
   output logic                   unexp_rsp_o
);

   localparam int unsigned IdxW = $clog2(NumMgr);
   localparam int unsigned CntW = $clog2(MaxTrans + 1);

   user_arb_state_e state_q, state_d;
   logic [IdxW-1:0] sel_q, sel_d;
   logic [IdxW-1:0] ptr_q, ptr_d;
   logic            unexp_q, unexp_d;

   logic [UserArbMaxMgr-1:0] req_pad;
   logic [IdxW-1:0]          rr_idx;
   logic [IdxW-1:0]          sel;
   logic                     sbr_req;
   logic                     handshake;
   logic                     rsp_route;
   logic                     rsp_unexp;

   logic [IdxW-1:0] fifo_head;
   logic            fifo_full;
   logic            fifo_empty;
   logic [CntW-1:0] fifo_cnt;

   user_arb_id_fifo #(
      .Depth (MaxTrans),
      .Width (IdxW)
   ) u_id_fifo (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .push_i      (handshake),
      .push_data_i (sel),
      .pop_i       (rsp_route),
      .head_o      (fifo_head),
      .full_o      (fifo_full),
      .empty_o     (fifo_empty),
      .count_o     (fifo_cnt)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= ArbIdle;
         sel_q   <= '0;
         ptr_q   <= '0;
         unexp_q <= 1'b0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         ptr_q   <= ptr_d;
         unexp_q <= unexp_d;
      end
   end

   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      ptr_d   = ptr_q;
      unexp_d = unexp_q | rsp_unexp;
      case (state_q)
         ArbIdle: begin
            if (sbr_req && !sbr_gnt_i) begin
               state_d = ArbHold;
               sel_d   = sel;
            end
         end
         ArbHold: begin
            if (sbr_gnt_i) state_d = ArbIdle;
         end
         default: state_d = ArbIdle;
      endcase
      if (handshake) ptr_d = (sel == IdxW'(NumMgr - 1)) ? '0 : sel + 1'b1;
   end

   // Outputs are gated by rst_i so the port reads idle for the whole reset pulse.
   always_comb begin
      req_pad                = '0;
      req_pad[NumMgr-1:0]    = mgr_req_i;
      rr_idx                 = IdxW'(user_arb_rr_pick(req_pad, 32'(ptr_q), NumMgr));
      sel                    = (state_q == ArbHold) ? sel_q : rr_idx;
      sbr_req                = ~rst_i & ((state_q == ArbHold) | ((|mgr_req_i) & ~fifo_full));
      handshake              = sbr_req & sbr_gnt_i;
      rsp_route              = ~rst_i & sbr_rvalid_i & ~fifo_empty;
      rsp_unexp              = sbr_rvalid_i & (fifo_cnt == '0);

      sbr_addr_o   = '0;
      sbr_wdata_o  = '0;
      sbr_we_o     = 1'b0;
      sbr_be_o     = '0;
      mgr_gnt_o    = '0;
      mgr_rvalid_o = '0;
      mgr_err_o    = '0;
      mgr_rdata_o  = '0;
      for (int i = 0; i < int'(NumMgr); i++) begin
         if (sel == IdxW'(i)) begin
            sbr_addr_o   = mgr_addr_i[i*32 +: 32];
            sbr_wdata_o  = mgr_wdata_i[i*32 +: 32];
            sbr_we_o     = mgr_we_i[i];
            sbr_be_o     = mgr_be_i[i*4 +: 4];
            mgr_gnt_o[i] = handshake;
         end
         if (rsp_route && fifo_head == IdxW'(i)) begin
            mgr_rvalid_o[i]          = 1'b1;
            mgr_err_o[i]             = sbr_err_i;
            mgr_rdata_o[i*32 +: 32]  = sbr_rdata_i;
         end
      end
   end

   assign sbr_req_o   = sbr_req;
   assign unexp_rsp_o = unexp_q;

endmodule

// File: tb/tb_user_obi_arbiter.sv
// Self-checking bench for user_obi_arbiter with two managers and two outstanding slots.
module tb_user_obi_arbiter;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic [1:0]  mgr_req_i;
   logic [1:0]  mgr_gnt_o;
   logic [63:0] mgr_addr_i;
   logic [63:0] mgr_wdata_i;
   logic [1:0]  mgr_we_i;
   logic [7:0]  mgr_be_i;
   logic [1:0]  mgr_rvalid_o;
   logic [1:0]  mgr_err_o;
   logic [63:0] mgr_rdata_o;
   logic        sbr_req_o;
   logic [31:0] sbr_addr_o;
   logic        sbr_we_o;
   logic [3:0]  sbr_be_o;
   logic [31:0] sbr_wdata_o;
   logic        sbr_gnt_i;
   logic        sbr_rvalid_i;
   logic        sbr_err_i;
   logic [31:0] sbr_rdata_i;
   logic        unexp_rsp_o;

   int   n_cmp = 0;
   int   n_bad = 0;
   logic exp_unexp = 1'b0;
   int   sb [$];

   user_obi_arbiter #(.NumMgr(2), .MaxTrans(2)) dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .mgr_req_i    (mgr_req_i),
      .mgr_gnt_o    (mgr_gnt_o),
      .mgr_addr_i   (mgr_addr_i),
      .mgr_wdata_i  (mgr_wdata_i),
      .mgr_we_i     (mgr_we_i),
      .mgr_be_i     (mgr_be_i),
      .mgr_rvalid_o (mgr_rvalid_o),
      .mgr_err_o    (mgr_err_o),
      .mgr_rdata_o  (mgr_rdata_o),
      .sbr_req_o    (sbr_req_o),
      .sbr_addr_o   (sbr_addr_o),
      .sbr_we_o     (sbr_we_o),
      .sbr_be_o     (sbr_be_o),
      .sbr_wdata_o  (sbr_wdata_o),
      .sbr_gnt_i    (sbr_gnt_i),
      .sbr_rvalid_i (sbr_rvalid_i),
      .sbr_err_i    (sbr_err_i),
      .sbr_rdata_i  (sbr_rdata_i),
      .unexp_rsp_o  (unexp_rsp_o)
   );

   always #5 clk_i = ~clk_i;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, expected completion before 100000");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [1:0]  req;
      logic        gnt;
      logic        rv;
      logic        er;
      logic [31:0] rd;
      logic [1:0]  eg;
      logic        ereq;
      int          esel;
   } vec_t;

   vec_t tbl [5];

   function automatic logic [31:0] addr_of(input int m);
      return 32'h1000_0000 + 32'(m) * 32'h100;
   endfunction

   function automatic logic [31:0] wdata_of(input int m);
      return 32'hD000_0000 + 32'(m);
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic step(input string nm, input logic [1:0] req, input logic gnt, input logic rv,
                       input logic er, input logic [31:0] rd, input logic [1:0] eg,
                       input logic ereq, input int esel);
      int e;
      mgr_req_i    = req;
      sbr_gnt_i    = gnt;
      sbr_rvalid_i = rv;
      sbr_err_i    = er;
      sbr_rdata_i  = rd;
      #2;
      chk({nm, ".gnt"},   32'(mgr_gnt_o),   32'(eg));
      chk({nm, ".req"},   32'(sbr_req_o),   32'(ereq));
      chk({nm, ".unexp"}, 32'(unexp_rsp_o), 32'(exp_unexp));
      if (esel >= 0) begin
         chk({nm, ".addr"},  sbr_addr_o,        addr_of(esel));
         chk({nm, ".wdata"}, sbr_wdata_o,       wdata_of(esel));
         chk({nm, ".we"},    32'(sbr_we_o),     32'(esel[0]));
         chk({nm, ".be"},    32'(sbr_be_o),     32'(4'hF - 4'(esel)));
      end
      if (rv && sb.size() > 0) begin
         e = sb.pop_front();
         chk({nm, ".rvalid"},  32'(mgr_rvalid_o),             32'(1) << e);
         chk({nm, ".rdata"},   mgr_rdata_o[e*32 +: 32],       rd);
         chk({nm, ".err"},     32'(mgr_err_o[e]),             32'(er));
         chk({nm, ".rdata_o"}, mgr_rdata_o[(1-e)*32 +: 32],   32'h0);
      end else begin
         chk({nm, ".rvalid"}, 32'(mgr_rvalid_o), 32'h0);
         if (rv) exp_unexp = 1'b1;
      end
      if (gnt && eg != 2'b00) sb.push_back(eg[1] ? 1 : 0);
      @(posedge clk_i);
      #1;
   endtask

   task automatic reset_checks(input string nm);
      chk({nm, ".req"},    32'(sbr_req_o),           32'h0);
      chk({nm, ".gnt"},    32'(mgr_gnt_o),           32'h0);
      chk({nm, ".rvalid"}, 32'(mgr_rvalid_o),        32'h0);
      chk({nm, ".err"},    32'(mgr_err_o),           32'h0);
      chk({nm, ".rdata"},  32'(mgr_rdata_o != '0),   32'h0);
      chk({nm, ".unexp"},  32'(unexp_rsp_o),         32'h0);
   endtask

   initial begin
      for (int m = 0; m < 2; m++) begin
         mgr_addr_i[m*32 +: 32]  = addr_of(m);
         mgr_wdata_i[m*32 +: 32] = wdata_of(m);
         mgr_we_i[m]             = m[0];
         mgr_be_i[m*4 +: 4]      = 4'hF - 4'(m);
      end
      rst_i = 1'b1; mgr_req_i = '0; sbr_gnt_i = 1'b0; sbr_rvalid_i = 1'b0;
      sbr_err_i = 1'b0; sbr_rdata_i = '0;

      // Alternating grants with responses overlapping new requests.
      tbl[0] = '{2'b11, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 2'b01, 1'b1, 0};
      tbl[1] = '{2'b11, 1'b1, 1'b1, 1'b0, 32'h0000_0100, 2'b10, 1'b1, 1};
      tbl[2] = '{2'b11, 1'b1, 1'b1, 1'b0, 32'h0000_0101, 2'b01, 1'b1, 0};
      tbl[3] = '{2'b11, 1'b1, 1'b1, 1'b0, 32'h0000_0102, 2'b10, 1'b1, 1};
      tbl[4] = '{2'b00, 1'b0, 1'b1, 1'b1, 32'h0000_0103, 2'b00, 1'b0, -1};

      repeat (2) @(posedge clk_i);
      #1;
      mgr_req_i = 2'b11; sbr_gnt_i = 1'b1; sbr_rvalid_i = 1'b1; sbr_rdata_i = 32'hFFFF_FFFF;
      #1;
      reset_checks("init_rst");
      mgr_req_i = '0; sbr_gnt_i = 1'b0; sbr_rvalid_i = 1'b0; sbr_rdata_i = '0;
      @(posedge clk_i);
      #1;
      rst_i = 1'b0;

      for (int i = 0; i < 5; i++)
         step($sformatf("rr%0d", i), tbl[i].req, tbl[i].gnt, tbl[i].rv, tbl[i].er,
              tbl[i].rd, tbl[i].eg, tbl[i].ereq, tbl[i].esel);

      // Locked selection: mgr 1 waits for grant while mgr 0 (higher priority) arrives.
      step("lock1", 2'b10, 1'b0, 1'b0, 1'b0, 32'h0, 2'b00, 1'b1, 1);
      step("lock2", 2'b11, 1'b0, 1'b0, 1'b0, 32'h0, 2'b00, 1'b1, 1);
      step("lock3", 2'b11, 1'b0, 1'b0, 1'b0, 32'h0, 2'b00, 1'b1, 1);
      step("lock4", 2'b11, 1'b1, 1'b0, 1'b0, 32'h0, 2'b10, 1'b1, 1);
      step("lock5", 2'b00, 1'b0, 1'b1, 1'b0, 32'h0000_0200, 2'b00, 1'b0, -1);

      // Outstanding limit: two handshakes fill the FIFO; a response reopens it next cycle.
      step("full1", 2'b01, 1'b1, 1'b0, 1'b0, 32'h0, 2'b01, 1'b1, 0);
      step("full2", 2'b01, 1'b1, 1'b0, 1'b0, 32'h0, 2'b01, 1'b1, 0);
      step("full3", 2'b01, 1'b1, 1'b0, 1'b0, 32'h0, 2'b00, 1'b0, -1);
      step("full4", 2'b01, 1'b1, 1'b1, 1'b0, 32'h0000_0300, 2'b00, 1'b0, -1);
      step("full5", 2'b01, 1'b1, 1'b0, 1'b0, 32'h0, 2'b01, 1'b1, 0);
      step("full6", 2'b00, 1'b0, 1'b1, 1'b0, 32'h0000_0301, 2'b00, 1'b0, -1);
      step("full7", 2'b00, 1'b0, 1'b1, 1'b0, 32'h0000_0302, 2'b00, 1'b0, -1);

      // In-order routing: grant 1 then 0, second response carries an error.
      step("ord1", 2'b11, 1'b1, 1'b0, 1'b0, 32'h0, 2'b10, 1'b1, 1);
      step("ord2", 2'b11, 1'b1, 1'b0, 1'b0, 32'h0, 2'b01, 1'b1, 0);
      step("ord3", 2'b00, 1'b0, 1'b1, 1'b0, 32'hAAAA_0001, 2'b00, 1'b0, -1);
      step("ord4", 2'b00, 1'b0, 1'b1, 1'b1, 32'h5555_0002, 2'b00, 1'b0, -1);

      // Unexpected response on an empty FIFO; flag must stick.
      step("unx1", 2'b00, 1'b0, 1'b1, 1'b0, 32'hDEAD_BEEF, 2'b00, 1'b0, -1);
      for (int i = 0; i < 3; i++)
         step($sformatf("unx_hold%0d", i), 2'b00, 1'b0, 1'b0, 1'b0, 32'h0, 2'b00, 1'b0, -1);

      // Reset with one transaction outstanding (pointer left at 1).
      step("prerst", 2'b01, 1'b1, 1'b0, 1'b0, 32'h0, 2'b01, 1'b1, 0);
      rst_i = 1'b1;
      mgr_req_i = 2'b11; sbr_gnt_i = 1'b1; sbr_rvalid_i = 1'b1; sbr_rdata_i = 32'h1234_5678;
      #1;
      reset_checks("mid_rst");
      mgr_req_i = '0; sbr_gnt_i = 1'b0; sbr_rvalid_i = 1'b0; sbr_rdata_i = '0;
      @(posedge clk_i);
      #1;
      rst_i = 1'b0;
      sb.delete();
      exp_unexp = 1'b0;

      step("post1", 2'b00, 1'b0, 1'b1, 1'b0, 32'h0000_0400, 2'b00, 1'b0, -1);
      step("post2", 2'b11, 1'b1, 1'b0, 1'b0, 32'h0, 2'b01, 1'b1, 0);
      step("post3", 2'b00, 1'b0, 1'b1, 1'b0, 32'h0000_0401, 2'b00, 1'b0, -1);
      step("post4", 2'b00, 1'b0, 1'b0, 1'b0, 32'h0, 2'b00, 1'b0, -1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/user_obi_arbiter.md
USER_OBI_ARBITER -- requirements
Module: user_obi_arbiter

Interface
REQ-001 SHALL have parameter NumMgr, default 2, number of OBI managers sharing the user-domain subordinate port (range 2..8).
REQ-002 SHALL have parameter MaxTrans, default 2, maximum outstanding granted-but-unanswered transactions (range 1..4).
REQ-003 SHALL have port clk_i  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst_i  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port mgr_req_i / mgr_gnt_o  input/output  NumMgr  per-manager OBI A-channel request/grant.
REQ-006 SHALL have port mgr_addr_i / mgr_wdata_i  input  NumMgr x 32  per-manager address/write data.
REQ-007 SHALL have port mgr_we_i / mgr_be_i  input  NumMgr x 1 / NumMgr x 4  per-manager write enable/byte enables.
REQ-008 SHALL have port mgr_rvalid_o / mgr_err_o / mgr_rdata_o  output  NumMgr / NumMgr / NumMgr x 32  per-manager R-channel.
REQ-009 SHALL have port sbr_req_o / sbr_addr_o / sbr_we_o / sbr_be_o / sbr_wdata_o  output  1/32/1/4/32  shared A-channel toward user demux.
REQ-010 SHALL have port sbr_gnt_i / sbr_rvalid_i / sbr_err_i / sbr_rdata_i  input  1/1/1/32  shared subordinate handshake and R-channel.
REQ-011 SHALL have port unexp_rsp_o  output  1  sticky flag: response received with no outstanding transaction.

Function
REQ-012 SHALL select one requesting manager per cycle by round-robin; priority pointer starts at index 0 and moves to (granted index + 1) mod NumMgr after each A-channel handshake.
REQ-013 SHALL drive sbr_req_o=1 and mux selected manager's addr/we/be/wdata when any mgr_req_i=1 and outstanding count < MaxTrans; otherwise sbr_req_o=0.
REQ-014 SHALL hold selection locked while sbr_req_o=1 and sbr_gnt_i=0 (OBI stability); a higher-priority newcomer SHALL NOT preempt.
REQ-015 SHALL assert mgr_gnt_o[i] combinationally = sbr_gnt_i & sbr_req_o & (selected==i); all other grants 0.
REQ-016 SHALL push granted index into an in-order ID FIFO on each handshake; zero-cycle latency added on A-channel.
REQ-017 SHALL route sbr_rvalid_i/sbr_err_i/sbr_rdata_i to FIFO-head manager in the same cycle and pop the head; other managers see rvalid=0, err=0, rdata=0.
REQ-018 SHALL support push and pop in the same cycle, count unchanged, including at full (MaxTrans) with pop freeing a slot only from next cycle.
REQ-019 SHALL, on sbr_rvalid_i with FIFO empty, route nothing and set unexp_rsp_o=1 until reset.
REQ-020 SHALL wrap the priority pointer from NumMgr-1 to 0 and FIFO pointers modulo MaxTrans.

Reset
REQ-021 SHALL, while rst_i=1, force pointer=0, FIFO empty, count=0, lock cleared, unexp_rsp_o=0, sbr_req_o=0, all mgr_gnt_o/mgr_rvalid_o/mgr_err_o=0, rdata outputs 0.
REQ-022 SHALL, on reset asserted mid-transaction, drop all outstanding IDs; responses arriving after release set unexp_rsp_o.

Structure
REQ-023 SHALL place UserArbNumMgr and UserArbMaxTrans constants and the manager-index typedef in user_pkg beside the user address map.
REQ-024 SHALL implement the ID FIFO as sub-module user_arb_id_fifo (depth MaxTrans, width clog2(NumMgr), full/empty/count outputs).

Verification
REQ-025 SHALL test: mgr 0 and 1 request simultaneously, sbr_gnt_i=1 constant -> grants alternate 0,1,0,1 starting with 0.
REQ-026 SHALL test: mgr 1 requests, sbr_gnt_i=0 for 3 cycles, mgr 0 requests meanwhile -> selection stays 1, addr stable, grant to 1 on 4th cycle.
REQ-027 SHALL test: MaxTrans=2, two handshakes, no response -> sbr_req_o=0 with pending request; one rvalid -> sbr_req_o=1 next cycle.
REQ-028 SHALL test: grants to 1 then 0, responses rdata 0xAAAA_0001 then 0x5555_0002 with err=1 on second -> mgr 1 gets 0xAAAA_0001 err 0, mgr 0 gets 0x5555_0002 err 1.
REQ-029 SHALL test: sbr_rvalid_i with no outstanding -> no mgr_rvalid_o, unexp_rsp_o=1 held until rst_i.
REQ-030 SHALL test: rst_i pulsed with one outstanding -> all outputs at reset values within the same cycle, pointer restarts at 0.
